// File: rtl/iopmp_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : iopmp_seq_checker
// Brief    : Multi-channel sequential IOPMP checker; walks a per-channel entry
//            list one entry per cycle. Optional error record: IOPMP_ERR_RECORD_EN.
// Revision : 1.0 - initial release
// ============================================================================

package iopmp_pkg;
    typedef enum logic [1:0] {
        IOPMP_OFF   = 2'd0,
        IOPMP_TOR   = 2'd1,
        IOPMP_NA4   = 2'd2,
        IOPMP_NAPOT = 2'd3
    } iopmp_mode_e;

    typedef struct packed {
        logic        r;
        logic        w;
        logic        x;
        iopmp_mode_e a;
    } entry_cfg;

    typedef enum logic [1:0] {
        IOPMP_READ  = 2'd0,
        IOPMP_WRITE = 2'd1,
        IOPMP_EXEC  = 2'd2
    } iopmp_req_e;
endpackage

module iopmp_seq_checker #(
    parameter int IOPMPNumChan     = 2,
    parameter int IOPMPRegions     = 16,
    parameter int IOPMPAddrW       = 34,
    parameter int IOPMPGranularity = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  iopmp_pkg::entry_cfg     csr_iopmp_i_cfg  [IOPMPRegions],
    input  logic [IOPMPAddrW-1:0]   csr_iopmp_addr_i [IOPMPRegions],
    input  logic [7:0]              md_entry_indexes [IOPMPNumChan][IOPMPRegions],
    input  logic [7:0]              last_indx        [IOPMPNumChan],
    input  logic [15:0]             prio_entry_num,
    input  logic [IOPMPNumChan-1:0] req_valid_i,
    output logic [IOPMPNumChan-1:0] req_ready_o,
    input  logic [IOPMPAddrW-1:0]   req_addr_i       [IOPMPNumChan],
    input  iopmp_pkg::iopmp_req_e   req_type_i       [IOPMPNumChan],
    output logic [IOPMPNumChan-1:0] rsp_valid_o,
    input  logic [IOPMPNumChan-1:0] rsp_ready_i,
    output logic [IOPMPNumChan-1:0] rsp_err_o,
`ifdef IOPMP_ERR_RECORD_EN
    output logic [IOPMPNumChan-1:0] err_rec_valid_o,
    output logic [IOPMPAddrW-1:0]   err_rec_addr_o   [IOPMPNumChan],
    output logic [7:0]              err_rec_idx_o    [IOPMPNumChan],
    input  logic [IOPMPNumChan-1:0] err_rec_clr_i,
`endif
    output logic [7:0]              rsp_idx_o        [IOPMPNumChan]
);

    localparam int c_IDXW = (IOPMPRegions > 1) ? $clog2(IOPMPRegions) : 1;
    localparam int c_LSB  = IOPMPGranularity + 2;
    localparam int c_FW   = IOPMPAddrW - c_LSB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    for (genvar ch = 0; ch < IOPMPNumChan; ch++) begin : g_chan
        state_e                  r_state, w_state_nxt;
        logic [IOPMPAddrW-1:0]   r_addr;
        iopmp_pkg::iopmp_req_e   r_type;
        logic [7:0]              r_pos, w_pos_nxt;
        logic                    r_err, w_err_nxt;
        logic [7:0]              r_idx, w_idx_nxt;
        logic                    w_latch;
        logic [7:0]              w_ent;
        logic                    w_ent_ok;
        logic [c_IDXW-1:0]       w_esel, w_esel_m1;
        iopmp_pkg::entry_cfg     w_cfg;
        logic [IOPMPAddrW-1:0]   w_ea, w_prev;
        logic [c_FW-1:0]         w_fld, w_care;
        logic                    w_match, w_perm, w_prio, w_last;

        // Tables are read live: the walk sees whatever is programmed this cycle.
        assign w_ent     = md_entry_indexes[ch][r_pos[c_IDXW-1:0]];
        assign w_ent_ok  = (w_ent < 8'(IOPMPRegions));
        assign w_esel    = w_ent[c_IDXW-1:0];
        assign w_esel_m1 = w_esel - c_IDXW'(1);
        assign w_cfg     = csr_iopmp_i_cfg[w_esel];
        assign w_ea      = csr_iopmp_addr_i[w_esel];
        assign w_prev    = (w_esel == '0) ? '0 : csr_iopmp_addr_i[w_esel_m1];
        assign w_fld     = w_ea[IOPMPAddrW-1:c_LSB];
        // Trailing ones plus the next zero bit are don't-care for NAPOT.
        assign w_care    = ~(w_fld ^ (w_fld + c_FW'(1)));
        assign w_prio    = ({8'h00, w_ent} < prio_entry_num);
        assign w_last    = (r_pos == (last_indx[ch] - 8'd1)) ||
                           (r_pos == 8'(IOPMPRegions - 1));

        always_comb begin
            w_match = 1'b0;
            case (w_cfg.a)
                iopmp_pkg::IOPMP_TOR:   w_match = (r_addr >= w_prev) && (r_addr < w_ea);
                iopmp_pkg::IOPMP_NA4:   w_match = (r_addr[IOPMPAddrW-1:c_LSB] == w_fld);
                iopmp_pkg::IOPMP_NAPOT: w_match = (((r_addr[IOPMPAddrW-1:c_LSB] ^ w_fld) & w_care) == '0);
                default:                w_match = 1'b0;
            endcase
            if (!w_ent_ok) begin
                w_match = 1'b0;
            end
        end

        always_comb begin
            w_perm = 1'b0;
            case (r_type)
                iopmp_pkg::IOPMP_READ:  w_perm = w_cfg.r;
                iopmp_pkg::IOPMP_WRITE: w_perm = w_cfg.w;
                iopmp_pkg::IOPMP_EXEC:  w_perm = w_cfg.x;
                default:                w_perm = 1'b0;
            endcase
        end

        always_comb begin
            w_state_nxt = r_state;
            w_pos_nxt   = r_pos;
            w_err_nxt   = r_err;
            w_idx_nxt   = r_idx;
            w_latch     = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i[ch]) begin
                        w_latch   = 1'b1;
                        w_pos_nxt = 8'd0;
                        if (last_indx[ch] == 8'd0) begin
                            w_state_nxt = ST_RESP;
                            w_err_nxt   = 1'b1;
                            w_idx_nxt   = 8'hFF;
                        end else begin
                            w_state_nxt = ST_WALK;
                        end
                    end
                end
                ST_WALK: begin
                    if (w_match && w_perm) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b0;
                        w_idx_nxt   = r_pos;
                    end else if ((w_match && w_prio) || w_last) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                        w_idx_nxt   = r_pos;
                    end else begin
                        w_pos_nxt = r_pos + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[ch]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_pos   <= 8'd0;
                r_err   <= 1'b0;
                r_idx   <= 8'd0;
                r_addr  <= '0;
                r_type  <= iopmp_pkg::IOPMP_READ;
            end else begin
                r_state <= w_state_nxt;
                r_pos   <= w_pos_nxt;
                r_err   <= w_err_nxt;
                r_idx   <= w_idx_nxt;
                if (w_latch) begin
                    r_addr <= req_addr_i[ch];
                    r_type <= req_type_i[ch];
                end
            end
        end

        assign req_ready_o[ch] = (r_state == ST_IDLE);
        assign rsp_valid_o[ch] = (r_state == ST_RESP);
        assign rsp_err_o[ch]   = r_err;
        assign rsp_idx_o[ch]   = r_idx;

`ifdef IOPMP_ERR_RECORD_EN
        logic                  r_rec_valid;
        logic [IOPMPAddrW-1:0] r_rec_addr;
        logic [7:0]            r_rec_idx;

        // Sticky until cleared; a clear beats a same-cycle capture.
        always_ff @(posedge clk) begin
            if (rst || err_rec_clr_i[ch]) begin
                r_rec_valid <= 1'b0;
                r_rec_addr  <= '0;
                r_rec_idx   <= 8'd0;
            end else if (!r_rec_valid && (r_state == ST_RESP) && rsp_ready_i[ch] && r_err) begin
                r_rec_valid <= 1'b1;
                r_rec_addr  <= r_addr;
                r_rec_idx   <= r_idx;
            end
        end

        assign err_rec_valid_o[ch] = r_rec_valid;
        assign err_rec_addr_o[ch]  = r_rec_addr;
        assign err_rec_idx_o[ch]   = r_rec_idx;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_iopmp_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_iopmp_seq_checker
// Brief    : Scoreboard bench for iopmp_seq_checker with a range-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iopmp_seq_checker;
    import iopmp_pkg::*;

    localparam int NC = 2;
    localparam int R  = 16;
    localparam int AW = 34;
    localparam int G  = 0;

    logic              clk = 1'b0;
    logic              rst;
    entry_cfg          csr_cfg  [R];
    logic [AW-1:0]     csr_addr [R];
    logic [7:0]        lists    [NC][R];
    logic [7:0]        last_indx [NC];
    logic [15:0]       prio;
    logic [NC-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [AW-1:0]     req_addr [NC];
    iopmp_req_e        req_type [NC];
    logic [7:0]        rsp_idx  [NC];
`ifdef IOPMP_ERR_RECORD_EN
    logic [NC-1:0]     rec_valid, rec_clr;
    logic [AW-1:0]     rec_addr [NC];
    logic [7:0]        rec_idx  [NC];
`endif

    logic [NC-1:0]     hold;
    bit                rand_ready;
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    typedef struct {
        int ch;
        bit err;
        int idx;
        int lat;
        int acc;
    } exp_t;
    exp_t sb[$];

    iopmp_seq_checker #(
        .IOPMPNumChan(NC), .IOPMPRegions(R), .IOPMPAddrW(AW), .IOPMPGranularity(G)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_iopmp_i_cfg(csr_cfg), .csr_iopmp_addr_i(csr_addr),
        .md_entry_indexes(lists), .last_indx(last_indx), .prio_entry_num(prio),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_type_i(req_type),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err),
`ifdef IOPMP_ERR_RECORD_EN
        .err_rec_valid_o(rec_valid), .err_rec_addr_o(rec_addr),
        .err_rec_idx_o(rec_idx), .err_rec_clr_i(rec_clr),
`endif
        .rsp_idx_o(rsp_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int ch, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s ch%0d: got 0x%0h, want 0x%0h (t=%0t)", name, ch, act, exp, $time);
        end
    endtask

    // Reference: each entry is turned into a byte range [lo, hi) and the list scanned in order.
    function automatic void model(input int ch, input longint a, input int t,
                                  output bit err, output int idx, output int lat);
        int     n, e, k;
        longint ea, lo, hi, f, gran, size;
        bit     hit, ok;
        n = (int'(last_indx[ch]) < R) ? int'(last_indx[ch]) : R;
        gran = longint'(1) << (G + 2);
        if (n == 0) begin
            err = 1'b1; idx = 255; lat = 1;
            return;
        end
        for (int p = 0; p < n; p++) begin
            e = int'(lists[ch][p]);
            hit = 1'b0;
            ok  = 1'b0;
            if (e < R) begin
                ea = longint'(csr_addr[e]);
                lo = 0; hi = 0;
                case (csr_cfg[e].a)
                    IOPMP_TOR: begin
                        lo = (e == 0) ? 0 : longint'(csr_addr[e-1]);
                        hi = ea;
                    end
                    IOPMP_NA4: begin
                        lo = ea - (ea % gran);
                        hi = lo + gran;
                    end
                    IOPMP_NAPOT: begin
                        f = ea / gran;
                        k = 0;
                        while (k < AW && f[k]) k++;
                        size = gran << (k + 1);
                        lo = ea - (ea % size);
                        hi = lo + size;
                    end
                    default: begin lo = 0; hi = 0; end
                endcase
                hit = (a >= lo) && (a < hi);
                ok  = (t == 0) ? csr_cfg[e].r : (t == 1) ? csr_cfg[e].w : csr_cfg[e].x;
            end
            if (hit && ok) begin
                err = 1'b0; idx = p; lat = p + 2;
                return;
            end
            if ((hit && e < int'(prio)) || p == n - 1) begin
                err = 1'b1; idx = p; lat = p + 2;
                return;
            end
        end
        err = 1'b1; idx = n - 1; lat = n + 1;
    endfunction

    task automatic issue(input int ch, input longint a, input int t,
                         input bit use_exp, input bit e_err, input int e_idx, input int e_lat);
        exp_t ex;
        bit   m_err;
        int   m_idx, m_lat;
        bit   got = 1'b0;
        @(posedge clk); #1;
        req_valid[ch] = 1'b1;
        req_addr[ch]  = AW'(a);
        req_type[ch]  = iopmp_req_e'(t);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready[ch]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept ch%0d: req_ready stayed 0, required 1 within 300 cycles", ch);
        end else begin
            if (use_exp) begin
                m_err = e_err; m_idx = e_idx; m_lat = e_lat;
            end else begin
                model(ch, a, t, m_err, m_idx, m_lat);
            end
            ex = '{ch: ch, err: m_err, idx: m_idx, lat: m_lat, acc: cyc};
            sb.push_back(ex);
        end
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    function automatic int find_head(input int ch);
        foreach (sb[i]) if (sb[i].ch == ch) return i;
        return -1;
    endfunction

    task automatic monitor(input int ch);
        bit   seen = 1'b0;
        int   hi;
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                continue;
            end
            if (rsp_valid[ch]) begin
                hi = find_head(ch);
                if (hi < 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp ch%0d: rsp_valid=1 with no request outstanding, required 0", ch);
                end else begin
                    h = sb[hi];
                    if (!seen) chk("latency", ch, cyc - h.acc, h.lat);
                    chk("rsp_err", ch, rsp_err[ch], h.err);
                    chk("rsp_idx", ch, rsp_idx[ch], h.idx);
                    chk("ready_in_resp", ch, req_ready[ch], 0);
                    seen = 1'b1;
                    if (rsp_ready[ch]) begin
                        sb.delete(hi);
                        seen = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (sb.size() != 0 || req_ready != '1); i++) @(negedge clk);
        chk("drain_empty", 0, sb.size(), 0);
    endtask

    task automatic issue_many(input int ch, input int n);
        longint a;
        int     off;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom % 3) @(posedge clk);
            if ($urandom % 2) begin
                a = longint'($urandom % 4096);
            end else begin
                off = int'($urandom % 5) - 2;
                a = longint'(csr_addr[$urandom % R]) + off;
                if (a < 0) a = 0;
            end
            issue(ch, a, int'($urandom % 3), 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        rsp_ready = '1;
        forever begin
            @(posedge clk); #1;
            for (int c = 0; c < NC; c++)
                rsp_ready[c] = hold[c] ? 1'b0 : (rand_ready ? 1'($urandom % 2) : 1'b1);
        end
    end

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 80000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; hold = '0; rand_ready = 1'b0; prio = 16'd0;
        for (int i = 0; i < R; i++) begin
            csr_cfg[i]  = '{r: 1'b0, w: 1'b0, x: 1'b0, a: IOPMP_OFF};
            csr_addr[i] = '0;
        end
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < R; i++) lists[c][i] = 8'd0;
            last_indx[c] = 8'd0;
            req_addr[c]  = '0;
            req_type[c]  = IOPMP_READ;
        end
`ifdef IOPMP_ERR_RECORD_EN
        rec_clr = '0;
`endif
        repeat (3) @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            chk("reset_ready", c, req_ready[c], 1);
            chk("reset_valid", c, rsp_valid[c], 0);
            chk("reset_err",   c, rsp_err[c], 0);
            chk("reset_idx",   c, rsp_idx[c], 0);
        end

        // TOR allow at entry 0
        csr_cfg[0]  = '{r: 1'b1, w: 1'b1, x: 1'b0, a: IOPMP_TOR};
        csr_addr[0] = 34'h100;
        lists[0][0] = 8'd0; last_indx[0] = 8'd1;
        issue(0, 'h40, 0, 1'b1, 1'b0, 0, 2);
        drain();

        // Priority NAPOT read-only entry denies a write
        csr_cfg[0]  = '{r: 1'b1, w: 1'b0, x: 1'b0, a: IOPMP_NAPOT};
        csr_addr[0] = 34'h20C;
        lists[0][1] = 8'd1; last_indx[0] = 8'd2; prio = 16'd1;
        issue(0, 'h200, 1, 1'b1, 1'b1, 0, 2);
        drain();

        // Non-priority: walk continues to an NA4 rw entry
        prio = 16'd0;
        csr_cfg[1]  = '{r: 1'b1, w: 1'b1, x: 1'b0, a: IOPMP_NA4};
        csr_addr[1] = 34'h200;
        issue(0, 'h200, 1, 1'b1, 1'b0, 1, 3);
        drain();

        // Empty list plus response back-pressure
        last_indx[0] = 8'd0;
        hold[0] = 1'b1;
        issue(0, 'h0, 0, 1'b1, 1'b1, 255, 1);
        repeat (6) @(posedge clk);
        hold[0] = 1'b0;
        drain();

        // Reset mid-walk drops the request
        for (int i = 0; i < R; i++) begin
            csr_cfg[i] = '{r: 1'b0, w: 1'b0, x: 1'b0, a: IOPMP_OFF};
            lists[0][i] = 8'(i);
        end
        last_indx[0] = 8'd8;
        issue(0, 'h0, 0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == 0) sb.delete(i);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_walk_ready", 0, req_ready[0], 1);
        chk("rst_walk_valid", 0, rsp_valid[0], 0);
        chk("rst_walk_err",   0, rsp_err[0], 0);
        chk("rst_walk_idx",   0, rsp_idx[0], 0);
        repeat (15) @(negedge clk);
        chk("rst_walk_quiet", 0, rsp_valid[0], 0);

        // Concurrent channels
        csr_cfg[0]  = '{r: 1'b1, w: 1'b1, x: 1'b0, a: IOPMP_TOR};
        csr_addr[0] = 34'h100;
        csr_cfg[1]  = '{r: 1'b1, w: 1'b0, x: 1'b0, a: IOPMP_NA4};
        csr_addr[1] = 34'h200;
        csr_cfg[2]  = '{r: 1'b1, w: 1'b1, x: 1'b0, a: IOPMP_TOR};
        csr_addr[2] = 34'h300;
        lists[0][0] = 8'd0; last_indx[0] = 8'd1;
        lists[1][0] = 8'd1; lists[1][1] = 8'd2; last_indx[1] = 8'd2;
        fork
            issue(0, 'h80, 1, 1'b1, 1'b0, 0, 2);
            issue(1, 'h200, 1, 1'b1, 1'b0, 1, 3);
        join
        drain();

`ifdef IOPMP_ERR_RECORD_EN
        rec_clr[0] = 1'b1;
        @(posedge clk); #1 rec_clr[0] = 1'b0;
        @(negedge clk);
        chk("rec_cleared", 0, rec_valid[0], 0);
        last_indx[0] = 8'd0;
        issue(0, 'h123, 0, 1'b1, 1'b1, 255, 1);
        drain();
        csr_cfg[0] = '{r: 1'b0, w: 1'b0, x: 1'b0, a: IOPMP_OFF};
        last_indx[0] = 8'd1;
        issue(0, 'h456, 2, 1'b1, 1'b1, 0, 2);
        drain();
        chk("rec_valid", 0, rec_valid[0], 1);
        chk("rec_addr",  0, rec_addr[0], 'h123);
        chk("rec_idx",   0, rec_idx[0], 255);
        last_indx[0] = 8'd0;
        issue(0, 'h789, 0, 1'b1, 1'b1, 255, 1);
        rec_clr[0] = 1'b1;
        @(posedge clk); #1 rec_clr[0] = 1'b0;
        drain();
        chk("rec_clr_wins", 0, rec_valid[0], 0);
`endif

        // Randomized batches; tables only change while all channels are idle
        rand_ready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < R; i++) begin
                csr_cfg[i]  = '{r: 1'($urandom % 2), w: 1'($urandom % 2),
                                x: 1'($urandom % 2), a: iopmp_mode_e'($urandom % 4)};
                csr_addr[i] = AW'($urandom % 4096);
            end
            for (int c = 0; c < NC; c++) begin
                for (int i = 0; i < R; i++) lists[c][i] = 8'($urandom % (R + 4));
                last_indx[c] = 8'($urandom % (R + 1));
            end
            prio = 16'($urandom % (R + 3));
            fork
                issue_many(0, 8);
                issue_many(1, 8);
            join
            drain();
        end
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
